alu_issue_stage: RTL

Registered issue stage that feeds the integer ALU. It accepts a decoded-but-unissued RV64 instruction word plus register-file operands over a valid/ready handshake. It produces the 4-bit ALU control code, the selected dataA/dataB operands and the destination register. A two-entry skid buffer gives full throughput with registered `in_ready`. It sits between register read and the ALU, and is the initiator of the ALU control encoding.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_op_decoder.sv | 86 ++++++++
 rtl/alu_issue_stage.sv | 117 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the integer ALU path: opcodes, ALU control codes and
// the issue-stage occupancy states.
package alu_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_SRA  = 4'b1101
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_state_e;

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational decode of an RV64 OP / OP-IMM word into ALU control and
// operands. Illegal words zero the control and operands but keep rd.
module alu_op_decoder
  import alu_pkg::*;
#(
  parameter int N = 64
) (
  input  logic [31:0]  instr,
  input  logic [N-1:0] rs1_data,
  input  logic [N-1:0] rs2_data,
  output logic [3:0]   alu_control,
  output logic [N-1:0] data_a,
  output logic [N-1:0] data_b,
  output logic [4:0]   rd,
  output logic         illegal
);

  logic [6:0]   opcode;
  logic [2:0]   funct3;
  logic [6:0]   funct7;
  logic [N-1:0] imm;
  logic [3:0]   ctrl;
  logic [N-1:0] opb;
  logic         legal;
  logic         unused_rs1_field;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign imm    = {{(N-12){instr[31]}}, instr[31:20]};
  // The rs1 index was consumed by register read upstream.
  assign unused_rs1_field = ^instr[19:15];

  always_comb begin
    ctrl  = ALU_ADD;
    opb   = rs2_data;
    legal = 1'b0;
    case (opcode)
      OPC_OP: begin
        if (funct7 == 7'b0000000) begin
          legal = 1'b1;
          ctrl  = {1'b0, funct3};
        end else if (funct7 == 7'b0100000 &&
                     (funct3 == 3'b000 || funct3 == 3'b101)) begin
          legal = 1'b1;
          ctrl  = {1'b1, funct3};
        end
      end
      OPC_OP_IMM: begin
        opb = imm;
        case (funct3)
          3'b000: begin
            legal = 1'b1;
            ctrl  = ALU_ADD;
          end
          3'b001: begin
            legal = (instr[31:26] == 6'b000000);
            ctrl  = ALU_SLL;
          end
          3'b101: begin
            // RV64 shamt is 6 bits, so only instr[31:26] selects SRL/SRA.
            if (instr[31:26] == 6'b000000) begin
              legal = 1'b1;
              ctrl  = ALU_SRL;
            end else if (instr[31:26] == 6'b010000) begin
              legal = 1'b1;
              ctrl  = ALU_SRA;
            end
          end
          default: begin
            legal = 1'b1;
            ctrl  = {1'b0, funct3};
          end
        endcase
      end
      default: legal = 1'b0;
    endcase
  end

  assign illegal     = ~legal;
  assign alu_control = legal ? ctrl : 4'b0000;
  assign data_a      = legal ? rs1_data : '0;
  assign data_b      = legal ? opb : '0;
  assign rd          = instr[11:7];

endmodule

// File: rtl/alu_issue_stage.sv
// Registered ALU issue stage: decodes at the input, then buffers decoded
// entries in an output register plus one skid register (FIFO order).
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_instr,
  input  logic [N-1:0] in_rs1_data,
  input  logic [N-1:0] in_rs2_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_dataA,
  output logic [N-1:0] out_dataB,
  output logic [3:0]   out_alu_control,
  output logic [4:0]   out_rd,
  output logic         out_illegal,
  output occ_state_e   dbg_state
);

  typedef struct packed {
    logic         illegal;
    logic [4:0]   rd;
    logic [3:0]   ctrl;
    logic [N-1:0] a;
    logic [N-1:0] b;
  } entry_t;

  // Handshake: a beat moves on a rising edge where valid and ready are both
  // high; in_ready depends only on registered state, never on out_ready.
  occ_state_e state_q, state_d;
  entry_t     dec, out_q, skid_q;
  logic       in_fire, out_fire;
  logic       load_out_dec, load_out_skid, load_skid;

  alu_op_decoder #(.N(N)) u_dec (
    .instr       (in_instr),
    .rs1_data    (in_rs1_data),
    .rs2_data    (in_rs2_data),
    .alu_control (dec.ctrl),
    .data_a      (dec.a),
    .data_b      (dec.b),
    .rd          (dec.rd),
    .illegal     (dec.illegal)
  );

  assign in_ready  = (state_q != OCC_TWO);
  assign out_valid = (state_q != OCC_EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_d       = state_q;
    load_out_dec  = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    if (flush) begin
      state_d = OCC_EMPTY;
    end else begin
      case (state_q)
        OCC_EMPTY: begin
          if (in_fire) begin
            load_out_dec = 1'b1;
            state_d      = OCC_ONE;
          end
        end
        OCC_ONE: begin
          case ({in_fire, out_fire})
            2'b11: load_out_dec = 1'b1;
            2'b10: begin
              load_skid = 1'b1;
              state_d   = OCC_TWO;
            end
            2'b01: state_d = OCC_EMPTY;
            default: state_d = OCC_ONE;
          endcase
        end
        OCC_TWO: begin
          if (out_fire) begin
            load_out_skid = 1'b1;
            state_d       = OCC_ONE;
          end
        end
        default: state_d = OCC_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= OCC_EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load_out_dec)
        out_q <= dec;
      else if (load_out_skid)
        out_q <= skid_q;
      if (load_skid)
        skid_q <= dec;
    end
  end

  assign out_dataA       = out_q.a;
  assign out_dataB       = out_q.b;
  assign out_alu_control = out_q.ctrl;
  assign out_rd          = out_q.rd;
  assign out_illegal     = out_q.illegal;
  assign dbg_state       = state_q;

endmodule
